keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg driver: scans a 4x4 Pmod keypad by strobing columns,
//  samples active-low rows, debounces, emits one key event per press. Keeps a 4-digit entry history
//  (digit0 = newest) wired straight to the display driver's digit0..digit3 inputs.
// PARAMETERS
//  SCAN_DIV        32768  clk1 cycles each column is driven (655 us at 50 MHz); must be >= 4
//  DEBOUNCE_SCANS  4      consecutive identical full scans required to accept a change; >= 1
// PORTS
//  clk1       in   1  system clock, single clock domain
//  rst1_n     in   1  asynchronous, active-low reset
//  row1       in   4  keypad rows, active low, asynchronous to clk1, external pull-ups
//  col1       out  4  keypad column strobes, active low, one-hot-low
//  clr        in   1  synchronous clear of the digit history
//  key_code   out  4  hex value of the last accepted key
//  key_valid  out  1  one-cycle pulse when a new key is accepted
//  key_down   out  1  level: an accepted key is currently held
//  digit0..3  out  4  entry history; digit0 = most recent key
// BEHAVIOUR
//  Reset: col1=4'b1110, div_cnt=0, col=0, key_code=0, key_valid=0, key_down=0, digit0..3=0, state=RELEASED.
//  row1 passes through a 2-flop synchronizer before any use.
//  div_cnt counts 0..SCAN_DIV-1; at wrap col increments mod 4; col1 = ~(4'b0001 << col), registered.
//  Rows sampled at div_cnt==SCAN_DIV-1 (end of dwell, lines settled), attributed to the current col.
//  Per-scan accumulator, cleared at col 0 start: counts pressed keys, keeps the code of the first
//   found (lowest col, then lowest row). At end of col 3 scan result = exactly one key ? {1,code} : NONE.
//   Two or more pressed keys -> NONE (ghosting rejected).
//  Key map [row][col]: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
//  Debounce: result == previous result -> stable_cnt++ (saturating), else stable_cnt=1. When
//   stable_cnt >= DEBOUNCE_SCANS and result differs from accepted value, accept it (once per change).
//  FSM states RELEASED / PRESSED, transitions on an acceptance only:
//   RELEASED, accept key K -> PRESSED: key_code=K, key_valid pulse, key_down=1, history shifts.
//   PRESSED, accept NONE   -> RELEASED: key_down=0, key_code holds, no pulse.
//   PRESSED K, accept K2!=K -> stays PRESSED: treated as new press of K2 (pulse, shift).
//  History shift: digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=K.
//  clr alone: digit0..3 <= 0 next cycle. clr with key_valid in the same cycle: digit0=K, digit1..3=0.
//   clr affects no other state.
//  Latency: press held stable from a scan boundary -> key_valid within (DEBOUNCE_SCANS+1)*4*SCAN_DIV+4 cycles.
//  Held key: exactly one key_valid, no auto-repeat. Reset mid-scan: all state returns to reset values
//   immediately; a key held through reset is reported once after full debounce.
//  Widths: div_cnt $clog2(SCAN_DIV); stable_cnt $clog2(DEBOUNCE_SCANS+1), saturating.
// STRUCTURE
//  keypad_pkg: key map function (row,col)->hex, NONE encoding (5-bit {valid,code}), FSM state constants.
//  One sub-module, keypad_debounce: compares scan results, runs stable_cnt, emits accept strobe and
//  value. Scanner, FSM and history stay in keypad_scan.
// TESTING (bench with SCAN_DIV=4, DEBOUNCE_SCANS=2; keypad model drives row1 from col1 and pressed set)
//  1 Reset, no keys -> col1 cycles 1110,1101,1011,0111 every 4 clk1; key_valid never asserts; digits 0.
//  2 Hold '5' (r1,c1) -> one key_valid, key_code=4'h5, key_down=1, digit0=5; release -> key_down=0, no pulse.
//  3 Press 1,2,3,A sequentially with releases -> digit3..0 = 1,2,3,A; then clr -> all digits 0.
//  4 Bounce: '7' toggled every scan for 5 scans, then stable -> exactly one key_valid, code 7.
//  5 Hold '1' and 'F' together -> no key_valid; release 'F' with '1' held -> accept 1 after debounce.
//  6 Assert rst1_n low mid-column while 'D' held -> outputs reset at once; after release of reset, one key_valid code D.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: scan-result encoding,
// FSM state constants and the row/column to hex key map.
package keypad_pkg;

  // Scan result is {valid, code}; all-zero means no single key was seen.
  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  localparam logic ST_RELEASED = 1'b0;
  localparam logic ST_PRESSED  = 1'b1;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Accepts a new scan result once it has been seen on DEBOUNCE_SCANS
// consecutive full scans and differs from the last accepted value.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk1,
  input  logic       rst1_n,
  input  logic       scan_done,
  input  logic [4:0] scan_res,
  output logic       accept,
  output logic [4:0] accept_val
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic [4:0]    prev_q, prev_d;
  logic [4:0]    accepted_q, accepted_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;

  always_comb begin
    prev_d       = prev_q;
    accepted_d   = accepted_q;
    stable_cnt_d = stable_cnt_q;
    accept       = 1'b0;
    if (scan_done) begin
      prev_d = scan_res;
      if (scan_res == prev_q) begin
        // Saturating at the threshold is enough to keep the accept condition true.
        if (stable_cnt_q < STABLE_MAX) stable_cnt_d = stable_cnt_q + 1'b1;
      end else begin
        stable_cnt_d = SW'(1);
      end
      if (stable_cnt_d >= STABLE_MAX && scan_res != accepted_q) begin
        accept     = 1'b1;
        accepted_d = scan_res;
      end
    end
  end

  assign accept_val = scan_res;

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      prev_q       <= KEY_NONE;
      accepted_q   <= KEY_NONE;
      stable_cnt_q <= '0;
    end else begin
      prev_q       <= prev_d;
      accepted_q   <= accepted_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobing, synchronized row sampling, press FSM
// and a 4-digit entry history (digit0 = newest) for the 7-seg driver.
//   state        | meaning
//   ST_RELEASED  | no accepted key held; next accepted key is a new press
//   ST_PRESSED   | accepted key held; NONE releases, a different key re-presses
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 32768,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk1,
  input  logic       rst1_n,
  input  logic [3:0] row1,
  output logic [3:0] col1,
  input  logic       clr,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col1_q, col1_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic [3:0]    digit0_q, digit1_q, digit2_q, digit3_q;
  logic [3:0]    digit0_d, digit1_d, digit2_d, digit3_d;

  logic       sample;
  logic       scan_done;
  logic [4:0] scan_res;
  logic       accept;
  logic [4:0] accept_val;
  logic       shift;
  logic [1:0] n_keys;
  logic [3:0] first_code;

  always_comb begin
    sample    = (div_cnt_q == DIV_LAST);
    div_cnt_d = sample ? '0 : div_cnt_q + 1'b1;
    col_d     = col_q;
    col1_d    = col1_q;
    if (sample) begin
      col_d  = col_q + 1'b1;
      col1_d = ~(4'b0001 << col_d);
    end
  end

  // Column 0 starts a fresh scan; the count saturates at 2 since only "exactly one" matters.
  always_comb begin
    n_keys     = (col_q == 2'd0) ? 2'd0 : acc_cnt_q;
    first_code = (col_q == 2'd0) ? 4'h0 : acc_code_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        if (n_keys == 2'd0) first_code = key_map(2'(r), col_q);
        if (n_keys != 2'd2) n_keys = n_keys + 2'd1;
      end
    end
    acc_cnt_d  = sample ? n_keys : acc_cnt_q;
    acc_code_d = sample ? first_code : acc_code_q;
    scan_done  = sample && (col_q == 2'd3);
    scan_res   = (n_keys == 2'd1) ? {1'b1, first_code} : KEY_NONE;
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk1      (clk1),
    .rst1_n    (rst1_n),
    .scan_done (scan_done),
    .scan_res  (scan_res),
    .accept    (accept),
    .accept_val(accept_val)
  );

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
    shift       = 1'b0;
    if (accept) begin
      if (accept_val[4]) begin
        state_d     = ST_PRESSED;
        key_code_d  = accept_val[3:0];
        key_valid_d = 1'b1;
        key_down_d  = 1'b1;
        shift       = 1'b1;
      end else if (state_q == ST_PRESSED) begin
        state_d    = ST_RELEASED;
        key_down_d = 1'b0;
      end
    end
  end

  always_comb begin
    digit0_d = digit0_q;
    digit1_d = digit1_q;
    digit2_d = digit2_q;
    digit3_d = digit3_q;
    if (shift) begin
      digit3_d = digit2_q;
      digit2_d = digit1_q;
      digit1_d = digit0_q;
      digit0_d = accept_val[3:0];
    end
    // A clear coinciding with a new key keeps only that key.
    if (clr) begin
      digit3_d = 4'h0;
      digit2_d = 4'h0;
      digit1_d = 4'h0;
      if (!shift) digit0_d = 4'h0;
    end
  end

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_cnt_q   <= '0;
      col_q       <= 2'd0;
      col1_q      <= 4'b1110;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      state_q     <= ST_RELEASED;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      digit0_q    <= 4'h0;
      digit1_q    <= 4'h0;
      digit2_q    <= 4'h0;
      digit3_q    <= 4'h0;
    end else begin
      row_s1_q    <= row1;
      row_s2_q    <= row_s1_q;
      div_cnt_q   <= div_cnt_d;
      col_q       <= col_d;
      col1_q      <= col1_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      digit0_q    <= digit0_d;
      digit1_q    <= digit1_d;
      digit2_q    <= digit2_d;
      digit3_q    <= digit3_d;
    end
  end

  assign col1      = col1_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign digit0    = digit0_q;
  assign digit1    = digit1_q;
  assign digit2    = digit2_q;
  assign digit3    = digit3_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 keypad driving the
// active-low rows from the column strobes and a set of pressed keys.
module tb_keypad_scan;

  logic       clk1 = 1'b0;
  logic       rst1_n = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] row1;
  logic [3:0] col1;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [3:0] digit0, digit1, digit2, digit3;

  // pressed[row*4 + col]
  logic [15:0] pressed = 16'h0000;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic [3:0] last_code = 4'h0;

  keypad_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk1     (clk1),
    .rst1_n   (rst1_n),
    .row1     (row1),
    .col1     (col1),
    .clr      (clr),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3)
  );

  always #5 clk1 = ~clk1;

  always_comb begin
    row1 = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row1[r] = ~|(pressed[r*4 +: 4] & ~col1);
    end
  end

  always @(negedge clk1) begin
    if (key_valid) begin
      pulses    <= pulses + 1;
      last_code <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk1);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!key_valid && n < budget) begin
      cyc(1);
      n++;
    end
    check(tag, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic press_release(input int idx, input logic [3:0] code, input string tag);
    int p0;
    p0 = pulses;
    pressed[idx] = 1'b1;
    cyc(80);
    check({tag, "_pulses"}, pulses - p0, 1);
    check({tag, "_code"}, {28'd0, last_code}, {28'd0, code});
    pressed[idx] = 1'b0;
    cyc(80);
  endtask

  initial begin
    int p0;
    logic [3:0] exp_col;

    // 1: reset and idle column rotation
    cyc(3);
    check("rst_col1", {28'd0, col1}, 32'hE);
    check("rst_key_valid", {31'd0, key_valid}, 0);
    check("rst_key_down", {31'd0, key_down}, 0);
    check("rst_key_code", {28'd0, key_code}, 0);
    check("rst_digit0", {28'd0, digit0}, 0);
    rst1_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << (k / 4));
      check("idle_col1", {28'd0, col1}, {28'd0, exp_col});
      cyc(1);
    end
    cyc(60);
    check("idle_pulses", pulses, 0);
    check("idle_digits", {16'd0, digit3, digit2, digit1, digit0}, 0);

    // 2: hold '5' then release
    p0 = pulses;
    pressed[5] = 1'b1;
    wait_valid(70, "t2_latency");
    check("t2_code", {28'd0, key_code}, 32'h5);
    check("t2_down", {31'd0, key_down}, 1);
    cyc(1);
    check("t2_pulse_width", {31'd0, key_valid}, 0);
    cyc(80);
    check("t2_held_pulses", pulses - p0, 1);
    check("t2_digit0", {28'd0, digit0}, 32'h5);
    check("t2_still_down", {31'd0, key_down}, 1);
    pressed[5] = 1'b0;
    cyc(80);
    check("t2_released", {31'd0, key_down}, 0);
    check("t2_release_pulses", pulses - p0, 1);
    check("t2_code_holds", {28'd0, key_code}, 32'h5);

    // 3: entry history then clear
    press_release(0, 4'h1, "t3_k1");
    press_release(1, 4'h2, "t3_k2");
    press_release(2, 4'h3, "t3_k3");
    press_release(3, 4'hA, "t3_kA");
    check("t3_history", {16'd0, digit3, digit2, digit1, digit0}, 32'h123A);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("t3_clr_digits", {16'd0, digit3, digit2, digit1, digit0}, 0);
    check("t3_clr_code", {28'd0, key_code}, 32'hA);

    // 4: '7' bouncing every scan, then stable
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      pressed[8] = (i % 2 == 0);
      cyc(16);
    end
    check("t4_bounce_pulses", pulses - p0, 0);
    cyc(80);
    check("t4_stable_pulses", pulses - p0, 1);
    check("t4_code", {28'd0, last_code}, 32'h7);
    check("t4_digit0", {28'd0, digit0}, 32'h7);
    pressed[8] = 1'b0;
    cyc(80);

    // 5: ghosting '1'+'F' rejected; release 'F' accepts '1'
    p0 = pulses;
    pressed[0]  = 1'b1;
    pressed[13] = 1'b1;
    cyc(96);
    check("t5_ghost_pulses", pulses - p0, 0);
    check("t5_ghost_down", {31'd0, key_down}, 0);
    pressed[13] = 1'b0;
    wait_valid(70, "t5_latency");
    check("t5_code", {28'd0, key_code}, 32'h1);
    cyc(80);
    check("t5_pulses", pulses - p0, 1);
    pressed = 16'h0000;
    cyc(80);
    check("t5_released", {31'd0, key_down}, 0);

    // 6: reset mid-column with 'D' held
    p0 = pulses;
    pressed[15] = 1'b1;
    cyc(10);
    rst1_n = 1'b0;
    #1;
    check("t6_rst_col1", {28'd0, col1}, 32'hE);
    check("t6_rst_code", {28'd0, key_code}, 0);
    check("t6_rst_down", {31'd0, key_down}, 0);
    check("t6_rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 0);
    cyc(3);
    rst1_n = 1'b1;
    wait_valid(70, "t6_latency");
    check("t6_code", {28'd0, key_code}, 32'hD);
    cyc(80);
    check("t6_pulses", pulses - p0, 1);
    check("t6_digit0", {28'd0, digit0}, 32'hD);
    pressed = 16'h0000;
    cyc(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
